// File: rtl/board_arbiter.sv
// Tic-tac-toe board registers plus a two-source move arbiter that
// replays accepted moves to the game FSM as a timed one-hot click.
module board_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       resetPosiciones,
  input  logic [8:0] almacenar_x,
  input  logic [8:0] almacenar_o,
  input  logic       turnoX,
  input  logic       ai_enable,
  input  logic       mouse_req,
  input  logic [8:0] mouse_cuadro,
  input  logic       ai_req,
  input  logic [8:0] ai_cuadro,
  output logic       mouse_ack,
  output logic       ai_ack,
  output logic       illegal,
  output logic [8:0] cuadro,
  output logic       busy,
  output logic [8:0] x,
  output logic [8:0] o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ?
                        HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] HLOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GLOAD = CW'(GAP_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  logic       own_mouse;
  logic       req;
  logic [8:0] req_cell;
  logic       one_hot;
  logic       free;
  logic       ok;
  logic [8:0] x_next;
  logic [8:0] o_next;

  always_comb begin
    own_mouse = ~ai_enable | turnoX;
    req       = own_mouse ? mouse_req : ai_req;
    req_cell  = own_mouse ? mouse_cuadro : ai_cuadro;
    one_hot   = (req_cell != 9'd0) &&
                ((req_cell & (req_cell - 9'd1)) == 9'd0);
    free      = ((x | o) & req_cell) == 9'd0;
    ok        = one_hot & free;
  end

  // X is resolved first so O can never claim a cell X takes this cycle
  always_comb begin
    x_next = x;
    o_next = o;
    if (resetPosiciones) begin
      x_next = 9'd0;
      o_next = 9'd0;
    end else begin
      x_next = x | almacenar_x;
      o_next = o | (almacenar_o & ~x_next);
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      x <= 9'd0;
      o <= 9'd0;
    end else begin
      x <= x_next;
      o <= o_next;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cuadro    <= 9'd0;
      busy      <= 1'b0;
      mouse_ack <= 1'b0;
      ai_ack    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      mouse_ack <= 1'b0;
      ai_ack    <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            mouse_ack <= own_mouse;
            ai_ack    <= ~own_mouse;
            if (ok) begin
              state  <= S_HOLD;
              cnt    <= HLOAD;
              cuadro <= req_cell;
              busy   <= 1'b1;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            state  <= S_GAP;
            cnt    <= GLOAD;
            cuadro <= 9'd0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          cnt    <= '0;
          cuadro <= 9'd0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_arbiter.sv
// Bench for board_arbiter: board table, directed click sequences,
// and randomized traffic against a transaction-level model.
module tb_board_arbiter;

  localparam int H = 4;
  localparam int G = 4;

  logic       clk_100MHz;
  logic       reset_n;
  logic       resetPosiciones;
  logic [8:0] almacenar_x;
  logic [8:0] almacenar_o;
  logic       turnoX;
  logic       ai_enable;
  logic       mouse_req;
  logic [8:0] mouse_cuadro;
  logic       ai_req;
  logic [8:0] ai_cuadro;
  logic       mouse_ack;
  logic       ai_ack;
  logic       illegal;
  logic [8:0] cuadro;
  logic       busy;
  logic [8:0] x;
  logic [8:0] o;

  board_arbiter #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk_100MHz     (clk_100MHz),
    .reset_n        (reset_n),
    .resetPosiciones(resetPosiciones),
    .almacenar_x    (almacenar_x),
    .almacenar_o    (almacenar_o),
    .turnoX         (turnoX),
    .ai_enable      (ai_enable),
    .mouse_req      (mouse_req),
    .mouse_cuadro   (mouse_cuadro),
    .ai_req         (ai_req),
    .ai_cuadro      (ai_cuadro),
    .mouse_ack      (mouse_ack),
    .ai_ack         (ai_ack),
    .illegal        (illegal),
    .cuadro         (cuadro),
    .busy           (busy),
    .x              (x),
    .o              (o)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [8:0] act,
                     input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic idle_inputs();
    resetPosiciones = 0;
    almacenar_x     = 0;
    almacenar_o     = 0;
    turnoX          = 1;
    ai_enable       = 0;
    mouse_req       = 0;
    mouse_cuadro    = 0;
    ai_req          = 0;
    ai_cuadro       = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 0;
    repeat (2) tick();
    reset_n = 1;
    tick();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 40) begin
      tick();
      k++;
    end
    chk("wait_idle_timeout", 9'(busy), 9'd0);
  endtask

  typedef struct {
    logic       rp;
    logic [8:0] ax;
    logic [8:0] ao;
    logic [8:0] ex;
    logic [8:0] eo;
  } bvec_t;

  bvec_t tbl[$];

  // model state
  logic [8:0] mx, mo, mcell;
  int         mt;

  task automatic model_step();
    logic       own_mouse;
    logic       r;
    logic [8:0] c;
    logic [8:0] nx, no;
    logic       e_mack, e_aack, e_ill;
    own_mouse = !ai_enable || turnoX;
    e_mack = 0;
    e_aack = 0;
    e_ill  = 0;
    if (mt >= 0) begin
      mt++;
      if (mt == H + G) mt = -1;
    end else begin
      r = own_mouse ? mouse_req : ai_req;
      c = own_mouse ? mouse_cuadro : ai_cuadro;
      if (r) begin
        if (own_mouse) e_mack = 1;
        else e_aack = 1;
        if ($countones(c) == 1 && ((mx | mo) & c) == 0) begin
          mt    = 0;
          mcell = c;
        end else begin
          e_ill = 1;
        end
      end
    end
    nx = resetPosiciones ? 9'd0 : (mx | almacenar_x);
    no = resetPosiciones ? 9'd0 : (mo | (almacenar_o & ~nx));
    mx = nx;
    mo = no;
    chk("rnd_mouse_ack", 9'(mouse_ack), 9'(e_mack));
    chk("rnd_ai_ack", 9'(ai_ack), 9'(e_aack));
    chk("rnd_illegal", 9'(illegal), 9'(e_ill));
    chk("rnd_cuadro", cuadro,
        (mt >= 0 && mt < H) ? mcell : 9'd0);
    chk("rnd_busy", 9'(busy), 9'(mt >= 0));
    chk("rnd_x", x, mx);
    chk("rnd_o", o, mo);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset_n = 0;
    idle_inputs();
    #12;
    chk("reset_x", x, 9'd0);
    chk("reset_o", o, 9'd0);
    chk("reset_cuadro", cuadro, 9'd0);
    chk("reset_busy", 9'(busy), 9'd0);
    chk("reset_acks", {7'd0, mouse_ack, ai_ack}, 9'd0);
    chk("reset_illegal", 9'(illegal), 9'd0);
    reset_n = 1;
    tick();

    // board update table
    tbl.push_back('{0, 9'h004, 9'h000, 9'h004, 9'h000});
    tbl.push_back('{0, 9'h004, 9'h000, 9'h004, 9'h000});
    tbl.push_back('{0, 9'h004, 9'h000, 9'h004, 9'h000});
    tbl.push_back('{0, 9'h000, 9'h004, 9'h004, 9'h000});
    tbl.push_back('{0, 9'h001, 9'h001, 9'h005, 9'h000});
    tbl.push_back('{0, 9'h000, 9'h002, 9'h005, 9'h002});
    tbl.push_back('{0, 9'h000, 9'h002, 9'h005, 9'h002});
    tbl.push_back('{1, 9'h100, 9'h000, 9'h000, 9'h000});
    tbl.push_back('{0, 9'h000, 9'h000, 9'h000, 9'h000});
    foreach (tbl[i]) begin
      resetPosiciones = tbl[i].rp;
      almacenar_x     = tbl[i].ax;
      almacenar_o     = tbl[i].ao;
      tick();
      chk($sformatf("tbl%0d_x", i), x, tbl[i].ex);
      chk($sformatf("tbl%0d_o", i), o, tbl[i].eo);
    end
    idle_inputs();

    // mouse-only click
    mouse_req = 1;
    mouse_cuadro = 9'h010;
    tick();
    chk("m_ack", 9'(mouse_ack), 9'd1);
    chk("m_illegal", 9'(illegal), 9'd0);
    chk("m_cuadro0", cuadro, 9'h010);
    chk("m_busy0", 9'(busy), 9'd1);
    mouse_req = 0;
    for (int k = 1; k < H + G; k++) begin
      tick();
      chk($sformatf("m_cuadro%0d", k), cuadro,
          (k < H) ? 9'h010 : 9'h000);
      chk($sformatf("m_busy%0d", k), 9'(busy), 9'd1);
      chk($sformatf("m_noack%0d", k), 9'(mouse_ack), 9'd0);
    end
    tick();
    chk("m_busy_end", 9'(busy), 9'd0);
    chk("m_cuadro_end", cuadro, 9'd0);

    // two-bit reject
    mouse_req = 1;
    mouse_cuadro = 9'h003;
    tick();
    chk("rej_ack", 9'(mouse_ack), 9'd1);
    chk("rej_illegal", 9'(illegal), 9'd1);
    chk("rej_cuadro", cuadro, 9'd0);
    chk("rej_busy", 9'(busy), 9'd0);
    mouse_req = 0;
    tick();
    chk("rej_ack_pulse", 9'(mouse_ack), 9'd0);
    chk("rej_ill_pulse", 9'(illegal), 9'd0);

    // occupied-cell reject
    almacenar_o = 9'h020;
    tick();
    almacenar_o = 0;
    chk("occ_o", o, 9'h020);
    mouse_req = 1;
    mouse_cuadro = 9'h020;
    tick();
    chk("occ_ack", 9'(mouse_ack), 9'd1);
    chk("occ_illegal", 9'(illegal), 9'd1);
    chk("occ_busy", 9'(busy), 9'd0);
    mouse_req = 0;
    tick();

    // ownership
    ai_enable = 1;
    turnoX = 1;
    mouse_req = 1;
    mouse_cuadro = 9'h001;
    ai_req = 1;
    ai_cuadro = 9'h100;
    tick();
    chk("own_mack", 9'(mouse_ack), 9'd1);
    chk("own_aack", 9'(ai_ack), 9'd0);
    chk("own_cuadro", cuadro, 9'h001);
    mouse_req = 0;
    for (int k = 1; k <= H + G; k++) begin
      tick();
      chk($sformatf("own_ai_wait%0d", k), 9'(ai_ack), 9'd0);
    end
    chk("own_idle", 9'(busy), 9'd0);
    turnoX = 0;
    tick();
    chk("own_aack2", 9'(ai_ack), 9'd1);
    chk("own_mack2", 9'(mouse_ack), 9'd0);
    chk("own_cuadro2", cuadro, 9'h100);
    ai_req = 0;
    wait_idle();
    tick();

    // board clear mid-HOLD
    apply_reset();
    almacenar_x = 9'h00c;
    tick();
    almacenar_x = 0;
    mouse_req = 1;
    mouse_cuadro = 9'h040;
    tick();
    mouse_req = 0;
    tick();
    resetPosiciones = 1;
    almacenar_x = 9'h100;
    tick();
    resetPosiciones = 0;
    almacenar_x = 0;
    chk("clr_x", x, 9'd0);
    chk("clr_o", o, 9'd0);
    chk("clr_cuadro", cuadro, 9'h040);
    chk("clr_busy", 9'(busy), 9'd1);
    wait_idle();
    tick();

    // async reset mid-HOLD with a pending request
    almacenar_x = 9'h080;
    tick();
    almacenar_x = 0;
    mouse_req = 1;
    mouse_cuadro = 9'h008;
    tick();
    mouse_cuadro = 9'h001;
    tick();
    #2;
    reset_n = 0;
    #1;
    chk("arst_cuadro", cuadro, 9'd0);
    chk("arst_busy", 9'(busy), 9'd0);
    chk("arst_x", x, 9'd0);
    chk("arst_o", o, 9'd0);
    tick();
    #2;
    reset_n = 1;
    tick();
    chk("arst_ack", 9'(mouse_ack), 9'd1);
    chk("arst_cuadro2", cuadro, 9'h001);
    mouse_req = 0;
    wait_idle();

    // randomized traffic vs model
    apply_reset();
    mx = 0;
    mo = 0;
    mcell = 0;
    mt = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      model_step();
      if (mouse_ack) mouse_req = 0;
      else if (!mouse_req && $urandom_range(3) == 0) begin
        mouse_req = 1;
        mouse_cuadro = ($urandom_range(4) == 0) ? 9'($urandom) :
                       9'(1 << $urandom_range(8));
      end
      if (ai_ack) ai_req = 0;
      else if (!ai_req && $urandom_range(3) == 0) begin
        ai_req = 1;
        ai_cuadro = ($urandom_range(4) == 0) ? 9'($urandom) :
                    9'(1 << $urandom_range(8));
      end
      if ($urandom_range(7) == 0) turnoX = ~turnoX;
      if ($urandom_range(15) == 0) ai_enable = ~ai_enable;
      almacenar_x = ($urandom_range(5) == 0) ?
                    9'(1 << $urandom_range(8)) : 9'd0;
      almacenar_o = ($urandom_range(5) == 0) ?
                    9'(1 << $urandom_range(8)) : 9'd0;
      resetPosiciones = ($urandom_range(39) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
